// File: rtl/segre_store_buffer_if.sv
// Port bundle between the store buffer and its TL-stage/MEM-stage neighbours.
// The master side drives stores, loads and drain grants; the slave side is the buffer.
interface segre_store_buffer_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
);
  logic                 store_i;
  logic                 load_i;
  logic [ADDR_SIZE-1:0] addr_i;
  logic [WORD_SIZE-1:0] data_i;
  logic [1:0]           memop_type_i;
  logic                 flush_en_i;
  logic                 full_o;
  logic                 empty_o;
  logic                 hit_o;
  logic                 conflict_o;
  logic [WORD_SIZE-1:0] data_load_o;
  logic                 flush_o;
  logic [ADDR_SIZE-1:0] flush_addr_o;
  logic [WORD_SIZE-1:0] flush_data_o;
  logic [1:0]           flush_type_o;

  modport master (
    output store_i, load_i, addr_i, data_i, memop_type_i, flush_en_i,
    input  full_o, empty_o, hit_o, conflict_o, data_load_o,
           flush_o, flush_addr_o, flush_data_o, flush_type_o
  );

  modport slave (
    input  store_i, load_i, addr_i, data_i, memop_type_i, flush_en_i,
    output full_o, empty_o, hit_o, conflict_o, data_load_o,
           flush_o, flush_addr_o, flush_data_o, flush_type_o
  );
endinterface

// File: rtl/segre_store_buffer.sv
// Committed-store FIFO between TL and MEM: forwards data to younger loads that hit
// and drains the oldest entry into the dcache whenever MEM grants a write slot.
module segre_store_buffer #(
  parameter int SB_DEPTH  = 4,
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  segre_store_buffer_if.slave sb
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(SB_DEPTH);

  logic [SB_DEPTH-1:0]  r_valid;
  logic [ADDR_SIZE-1:0] r_addr [SB_DEPTH];
  logic [WORD_SIZE-1:0] r_data [SB_DEPTH];
  logic [1:0]           r_type [SB_DEPTH];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [PW:0]          r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [PW-1:0]        w_age_idx [SB_DEPTH];
  logic                 w_found;
  logic [PW-1:0]        w_win;
  logic                 w_exact;

  assign w_full  = (r_count == DEPTH_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = sb.store_i && !w_full;
  assign w_pop   = sb.flush_en_i && !w_empty;

  // Entry indices ordered oldest (head) to youngest, so priority survives the wrap.
  always_comb begin
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_age_idx[i] = r_head + PW'(i);
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = r_head;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (r_valid[w_age_idx[i]] &&
          (r_addr[w_age_idx[i]][ADDR_SIZE-1:2] == sb.addr_i[ADDR_SIZE-1:2])) begin
        w_found = 1'b1;
        w_win   = w_age_idx[i];
      end
    end
  end

  assign w_exact = (r_addr[w_win] == sb.addr_i) && (r_type[w_win] == sb.memop_type_i);

  assign sb.full_o       = w_full;
  assign sb.empty_o      = w_empty;
  assign sb.hit_o        = sb.load_i && w_found && w_exact;
  assign sb.conflict_o   = sb.load_i && w_found && !w_exact;
  assign sb.data_load_o  = r_data[w_win];
  assign sb.flush_o      = w_pop;
  assign sb.flush_addr_o = r_addr[r_head];
  assign sb.flush_data_o = r_data[r_head];
  assign sb.flush_type_o = r_type[r_head];

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Push and pop never target the same slot: that needs head==tail, i.e. full or empty.
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
    end
  end

  // Payloads are left intact by reset; valid bits alone define occupancy.
  always_ff @(posedge clk_i) begin
    if (w_push && !rsn_i) begin
      r_addr[r_tail] <= sb.addr_i;
      r_data[r_tail] <= sb.data_i;
      r_type[r_tail] <= sb.memop_type_i;
    end
  end

  a_one_memop: assert property (@(posedge clk_i) disable iff (rsn_i)
                                !(sb.store_i && sb.load_i));
endmodule

// File: doc/segre_store_buffer.md
Name: segre_store_buffer

Overview:
- Store buffer that sits between the TL stage and the MEM stage.
- It captures committed stores in a small FIFO and forwards store data to younger loads that hit.
- It drains entries one per cycle into the dcache data array whenever the MEM stage grants a write slot.
- It is the producer of the sb_hit/sb_data_load lookup signals and the sb_flush/sb_data_flush/sb_addr/flush-type signals that the MEM stage consumes.

Parameters:
- SB_DEPTH, 4, number of entries; power of 2, at least 2.
- ADDR_SIZE, 32, address width.
- WORD_SIZE, 32, data width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rsn_i  in  1  reset; synchronous, active-high (1 = reset).
- store_i  in  1  TL stage: push a store this cycle.
- load_i  in  1  TL stage: look up a load this cycle.
- addr_i  in  ADDR_SIZE  store/load byte address.
- data_i  in  WORD_SIZE  store data, right-aligned.
- memop_type_i  in  2  memop_data_type_e: BYTE, HALF, WORD.
- flush_en_i  in  1  MEM stage grants a dcache write slot this cycle.
- full_o  out  1  count == SB_DEPTH.
- empty_o  out  1  count == 0.
- hit_o  out  1  load forwarded from the buffer (drives sb_hit_i).
- conflict_o  out  1  load overlaps a buffered store that cannot be forwarded; TL must stall.
- data_load_o  out  WORD_SIZE  forwarded data (drives sb_data_load_i).
- flush_o  out  1  head entry written to dcache this cycle (drives sb_flush_i).
- flush_addr_o  out  ADDR_SIZE  head address (drives sb_addr_i).
- flush_data_o  out  WORD_SIZE  head data (drives sb_data_flush_i).
- flush_type_o  out  2  head type (drives memop_type_flush_i).

Behaviour:
- State: per entry {valid, addr, data, type}; head/tail pointers (log2 SB_DEPTH bits, wrap modulo SB_DEPTH); count (log2 SB_DEPTH + 1 bits).
- Reset (rsn_i=1 at an edge): all valid=0, head=tail=count=0.
  - Outputs after reset: full_o=0, empty_o=1, hit_o=0, conflict_o=0, flush_o=0.
  - data_load_o, flush_addr_o, flush_data_o, flush_type_o read from the head entry and are don't-care while flush_o=0; entry payloads are not cleared.
  - Reset mid-operation discards all buffered stores; this is not an error.
- Push: store_i && !full_o.
  - Write entry[tail] = {1, addr_i, data_i, memop_type_i}, then tail++.
  - store_i while full_o: store is dropped and the buffer is unchanged. The TL stage must stall on full_o; the bench flags this as a protocol violation.
- store_i and load_i are mutually exclusive (one memop per cycle). An assertion fires if both are high.
- Lookup (combinational, same cycle as load_i, evaluated on pre-edge state):
  - Candidate set: valid entries with addr[ADDR_SIZE-1:2] == addr_i[ADDR_SIZE-1:2].
  - The youngest candidate wins; age is measured from head, so the entry closest to tail-1 has highest priority.
  - Winner has addr == addr_i and type == memop_type_i: hit_o=1, conflict_o=0, data_load_o = winner.data, raw and unextended (the MEM stage sign-extends).
  - Winner differs in offset or size: hit_o=0, conflict_o=1.
  - No candidate: hit_o=0, conflict_o=0.
  - load_i=0 forces hit_o=0 and conflict_o=0.
- Flush (drain):
  - flush_o = flush_en_i && !empty_o.
  - flush_addr_o, flush_data_o and flush_type_o come from entry[head], combinationally.
  - At the edge where flush_o=1: valid[head]=0, head++.
- Count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Push is still blocked if full_o was 1 at the start of the cycle, even when a pop occurs that same cycle.
- Simultaneous load hit and flush of the same entry: forwarding uses pre-pop state, so the data stays correct.
- Wrap-around: after SB_DEPTH pushes, tail returns to 0. Age priority is computed relative to head, so forwarding stays correct across the wrap.
- Latency:
  - Push visible to a lookup from the next cycle.
  - Minimum store-to-dcache latency is 1 cycle (push at cycle N, flush_o at N+1 if flush_en_i).

Test Plan:
- Reset, then push WORD 0x100 = 0xDEADBEEF, next cycle load WORD 0x100 -> hit_o=1, data_load_o=0xDEADBEEF, conflict_o=0, empty_o=0.
- Push WORD 0x200 = 0x1, then WORD 0x200 = 0x2, load WORD 0x200 -> hit_o=1, data_load_o=0x2 (youngest wins).
- Push WORD 0x300 = 0xAABBCCDD, load BYTE 0x301 -> conflict_o=1, hit_o=0. Load WORD 0x400 -> hit_o=0, conflict_o=0.
- Push 4 stores (full_o=1), assert store_i 0x500 -> dropped. Set flush_en_i for 4 cycles -> flush_o=1 each cycle, flush_addr_o in push order, then empty_o=1 and flush_o=0.
- Steady stream: store_i and flush_en_i high together for 10 cycles -> count stays 1, pointers wrap past SB_DEPTH, each flush_data_o equals the data pushed one cycle earlier.
- Fill 3 entries, assert rsn_i=1 for one cycle -> empty_o=1, full_o=0. Subsequent load to a previously buffered address -> hit_o=0.
